// File: rtl/procyon_wb_pkg.sv
// Shared Wishbone definitions for the procyon core bus fabric.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package procyon_wb_pkg;

   // Field widths of the Wishbone cycle-type and burst-type tags
   localparam int WB_CTI_WIDTH = 3;
   localparam int WB_BTE_WIDTH = 2;

   // Cycle type identifier encodings
   localparam logic [WB_CTI_WIDTH-1:0] WB_CTI_CLASSIC = 3'b000;
   localparam logic [WB_CTI_WIDTH-1:0] WB_CTI_INCR    = 3'b010;
   localparam logic [WB_CTI_WIDTH-1:0] WB_CTI_EOB     = 3'b111;

   // Burst type extension encodings
   localparam logic [WB_BTE_WIDTH-1:0] WB_BTE_LINEAR  = 2'b00;

   // Arbiter ownership state: nobody owns the slave, or one master does
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } wb_arb_state_t;

endpackage

// File: rtl/wb_rr_picker.sv
// Round-robin picker: first requester strictly after the last owner, wrapping.
// Latency: purely combinational.
// Backpressure: none; the result is recomputed from the live request vector.
module wb_rr_picker #(
   parameter int M = 2
) (
   input  logic [M-1:0] req,
   input  logic [M-1:0] last,
   output logic [M-1:0] pick,
   output logic         pick_vld
);

   localparam int IW = (M > 1) ? $clog2(M) : 1;

   logic [IW-1:0] last_idx;
   logic [IW-1:0] shift;
   logic [M-1:0]  rot;
   logic [M-1:0]  rot_ffs;

   // Convert the one-hot last owner into an index
   always_comb begin
      last_idx = '0;
      for (int i = 0; i < M; i++) begin
         if (last[i]) begin
            last_idx = IW'(i);
         end
      end
   end

   // Rotation amount is last+1 modulo M, so the previous owner ranks lowest
   always_comb begin
      if (last_idx == IW'(M - 1)) begin
         shift = '0;
      end else begin
         shift = last_idx + 1'b1;
      end
   end

   // Rotate requests so that bit 0 is the master right after the last owner
   always_comb begin
      rot = '0;
      for (int i = 0; i < M; i++) begin
         int k;
         k = i + int'(shift);
         if (k >= M) begin
            k = k - M;
         end
         rot[i] = req[k[IW-1:0]];
      end
   end

   // Find-first-set on the rotated vector
   always_comb begin
      logic found;
      rot_ffs = '0;
      found   = 1'b0;
      for (int i = 0; i < M; i++) begin
         if (rot[i] && !found) begin
            rot_ffs[i] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   // Rotate the winner back into master numbering
   always_comb begin
      pick = '0;
      for (int i = 0; i < M; i++) begin
         int k;
         k = i + int'(shift);
         if (k >= M) begin
            k = k - M;
         end
         pick[k[IW-1:0]] = rot_ffs[i];
      end
   end

   assign pick_vld = |req;

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave port among M masters per bus cycle.
// Latency: 1 cycle from CYC rise to grant when idle; zero-gap handoff between owners.
// Backpressure: losers are stalled by withholding grant; they must hold CYC until granted.
module wb_arbiter
   import procyon_wb_pkg::*;
#(
   parameter int OPTN_NUM_MASTERS   = 2,
   parameter int OPTN_WB_DATA_WIDTH = 32,
   parameter int OPTN_WB_ADDR_WIDTH = 32
) (
   input  logic                                         i_wb_clk,
   input  logic                                         i_wb_rst,

   input  logic [OPTN_NUM_MASTERS-1:0]                  i_m_cyc,
   input  logic [OPTN_NUM_MASTERS-1:0]                  i_m_stb,
   input  logic [OPTN_NUM_MASTERS-1:0]                  i_m_we,
   input  logic [OPTN_NUM_MASTERS*WB_CTI_WIDTH-1:0]     i_m_cti,
   input  logic [OPTN_NUM_MASTERS*WB_BTE_WIDTH-1:0]     i_m_bte,
   input  logic [OPTN_NUM_MASTERS*(OPTN_WB_DATA_WIDTH/8)-1:0] i_m_sel,
   input  logic [OPTN_NUM_MASTERS*OPTN_WB_ADDR_WIDTH-1:0] i_m_addr,
   input  logic [OPTN_NUM_MASTERS*OPTN_WB_DATA_WIDTH-1:0] i_m_data,
   output logic [OPTN_NUM_MASTERS-1:0]                  o_m_ack,
   output logic [OPTN_WB_DATA_WIDTH-1:0]                o_m_data,

   output logic                                         o_wb_cyc,
   output logic                                         o_wb_stb,
   output logic                                         o_wb_we,
   output logic [WB_CTI_WIDTH-1:0]                      o_wb_cti,
   output logic [WB_BTE_WIDTH-1:0]                      o_wb_bte,
   output logic [OPTN_WB_DATA_WIDTH/8-1:0]              o_wb_sel,
   output logic [OPTN_WB_ADDR_WIDTH-1:0]                o_wb_addr,
   output logic [OPTN_WB_DATA_WIDTH-1:0]                o_wb_data,
   input  logic                                         i_wb_ack,
   input  logic [OPTN_WB_DATA_WIDTH-1:0]                i_wb_data,

   output logic [OPTN_NUM_MASTERS-1:0]                  o_gnt
);

   localparam int M = OPTN_NUM_MASTERS;
   localparam int D = OPTN_WB_DATA_WIDTH;
   localparam int A = OPTN_WB_ADDR_WIDTH;
   localparam int S = OPTN_WB_DATA_WIDTH / 8;

   wb_arb_state_t state;
   wb_arb_state_t state_nxt;
   logic [M-1:0]  gnt;
   logic [M-1:0]  gnt_nxt;
   logic [M-1:0]  last;
   logic [M-1:0]  last_nxt;

   logic [M-1:0]  pick;
   logic          pick_vld;
   logic          owner_cyc;

   // The picker sees live CYC only; non-owners are expected to hold their request.
   // In BUSY, last equals gnt, so the outgoing owner is ranked lowest.
   wb_rr_picker #(
      .M (M)
   ) u_picker (
      .req      (i_m_cyc),
      .last     (last),
      .pick     (pick),
      .pick_vld (pick_vld)
   );

   assign owner_cyc = |(i_m_cyc & gnt);

   // State, grant and last-owner registers; reset leaves master M-1 as last so master 0 wins first
   always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
      if (i_wb_rst) begin
         state <= IDLE;
         gnt   <= '0;
         last  <= M'(1) << (M - 1);
      end else begin
         state <= state_nxt;
         gnt   <= gnt_nxt;
         last  <= last_nxt;
      end
   end

   // Ownership transitions: grant on CYC, hold through the whole bus cycle, hand off on release
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      last_nxt  = last;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               state_nxt = BUSY;
               gnt_nxt   = pick;
               last_nxt  = pick;
            end
         end
         BUSY: begin
            // CTI/BTE are ignored: holding CYC alone keeps a burst intact
            if (!owner_cyc) begin
               if (pick_vld) begin
                  gnt_nxt  = pick;
                  last_nxt = pick;
               end else begin
                  state_nxt = IDLE;
                  gnt_nxt   = '0;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
   end

   // Owner mux as AND-OR over one-hot gnt; an all-zero gnt drives the slave side to zero
   always_comb begin
      o_wb_cyc  = 1'b0;
      o_wb_stb  = 1'b0;
      o_wb_we   = 1'b0;
      o_wb_cti  = '0;
      o_wb_bte  = '0;
      o_wb_sel  = '0;
      o_wb_addr = '0;
      o_wb_data = '0;
      for (int k = 0; k < M; k++) begin
         o_wb_cyc  = o_wb_cyc | (gnt[k] & i_m_cyc[k]);
         o_wb_stb  = o_wb_stb | (gnt[k] & i_m_cyc[k] & i_m_stb[k]);
         o_wb_we   = o_wb_we  | (gnt[k] & i_m_we[k]);
         o_wb_cti  = o_wb_cti  | ({WB_CTI_WIDTH{gnt[k]}} & i_m_cti[k*WB_CTI_WIDTH +: WB_CTI_WIDTH]);
         o_wb_bte  = o_wb_bte  | ({WB_BTE_WIDTH{gnt[k]}} & i_m_bte[k*WB_BTE_WIDTH +: WB_BTE_WIDTH]);
         o_wb_sel  = o_wb_sel  | ({S{gnt[k]}} & i_m_sel[k*S +: S]);
         o_wb_addr = o_wb_addr | ({A{gnt[k]}} & i_m_addr[k*A +: A]);
         o_wb_data = o_wb_data | ({D{gnt[k]}} & i_m_data[k*D +: D]);
      end
   end

   // ACK goes to the owner only, including the cycle in which it drops CYC; dropped when idle
   always_comb begin
      o_m_ack = gnt & {M{i_wb_ack}};
   end

   assign o_m_data = i_wb_data;
   assign o_gnt    = gnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a 2-master and a 3-master instance.
// Latency: checks 1-cycle grant and zero-gap handoff.
// Backpressure: masters hold CYC until granted.
module tb_wb_arbiter;
   import procyon_wb_pkg::*;

   logic clk;
   int   n_checks;
   int   n_errors;

   // ---------------- two-master instance ----------------
   logic        rst;
   logic [1:0]  m_cyc, m_stb, m_we;
   logic [5:0]  m_cti;
   logic [3:0]  m_bte;
   logic [7:0]  m_sel;
   logic [63:0] m_addr, m_data;
   logic [1:0]  m_ack;
   logic [31:0] m_rdata;
   logic        wb_cyc, wb_stb, wb_we;
   logic [2:0]  wb_cti;
   logic [1:0]  wb_bte;
   logic [3:0]  wb_sel;
   logic [31:0] wb_addr, wb_data;
   logic        wb_ack;
   logic [31:0] wb_rdata;
   logic [1:0]  gnt;

   wb_arbiter #(
      .OPTN_NUM_MASTERS   (2),
      .OPTN_WB_DATA_WIDTH (32),
      .OPTN_WB_ADDR_WIDTH (32)
   ) u_dut (
      .i_wb_clk  (clk),
      .i_wb_rst  (rst),
      .i_m_cyc   (m_cyc),
      .i_m_stb   (m_stb),
      .i_m_we    (m_we),
      .i_m_cti   (m_cti),
      .i_m_bte   (m_bte),
      .i_m_sel   (m_sel),
      .i_m_addr  (m_addr),
      .i_m_data  (m_data),
      .o_m_ack   (m_ack),
      .o_m_data  (m_rdata),
      .o_wb_cyc  (wb_cyc),
      .o_wb_stb  (wb_stb),
      .o_wb_we   (wb_we),
      .o_wb_cti  (wb_cti),
      .o_wb_bte  (wb_bte),
      .o_wb_sel  (wb_sel),
      .o_wb_addr (wb_addr),
      .o_wb_data (wb_data),
      .i_wb_ack  (wb_ack),
      .i_wb_data (wb_rdata),
      .o_gnt     (gnt)
   );

   // ---------------- three-master instance ----------------
   logic        rst3;
   logic [2:0]  m_cyc3, m_stb3, m_we3;
   logic [8:0]  m_cti3;
   logic [5:0]  m_bte3;
   logic [11:0] m_sel3;
   logic [95:0] m_addr3, m_data3;
   logic [2:0]  m_ack3;
   logic [31:0] m_rdata3;
   logic        wb_cyc3, wb_stb3, wb_we3;
   logic [2:0]  wb_cti3;
   logic [1:0]  wb_bte3;
   logic [3:0]  wb_sel3;
   logic [31:0] wb_addr3, wb_data3;
   logic        wb_ack3;
   logic [31:0] wb_rdata3;
   logic [2:0]  gnt3;

   wb_arbiter #(
      .OPTN_NUM_MASTERS   (3),
      .OPTN_WB_DATA_WIDTH (32),
      .OPTN_WB_ADDR_WIDTH (32)
   ) u_dut3 (
      .i_wb_clk  (clk),
      .i_wb_rst  (rst3),
      .i_m_cyc   (m_cyc3),
      .i_m_stb   (m_stb3),
      .i_m_we    (m_we3),
      .i_m_cti   (m_cti3),
      .i_m_bte   (m_bte3),
      .i_m_sel   (m_sel3),
      .i_m_addr  (m_addr3),
      .i_m_data  (m_data3),
      .o_m_ack   (m_ack3),
      .o_m_data  (m_rdata3),
      .o_wb_cyc  (wb_cyc3),
      .o_wb_stb  (wb_stb3),
      .o_wb_we   (wb_we3),
      .o_wb_cti  (wb_cti3),
      .o_wb_bte  (wb_bte3),
      .o_wb_sel  (wb_sel3),
      .o_wb_addr (wb_addr3),
      .o_wb_data (wb_data3),
      .i_wb_ack  (wb_ack3),
      .i_wb_data (wb_rdata3),
      .o_gnt     (gnt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                        input logic [2:0] cti, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel);
      m_cyc[k]           = cyc;
      m_stb[k]           = stb;
      m_we[k]            = we;
      m_cti[k*3 +: 3]    = cti;
      m_addr[k*32 +: 32] = addr;
      m_data[k*32 +: 32] = data;
      m_sel[k*4 +: 4]    = sel;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      logic [1:0] exp_g;
      logic [2:0] exp3;
      n_checks = 0;
      n_errors = 0;

      rst = 1'b1;
      m_cyc = '0; m_stb = '0; m_we = '0; m_cti = '0; m_bte = '0;
      m_sel = '0; m_addr = '0; m_data = '0;
      wb_ack = 1'b1;
      wb_rdata = 32'hDEAD_BEEF;
      rst3 = 1'b1;
      m_cyc3 = '0; m_stb3 = '0; m_we3 = '0; m_cti3 = '0; m_bte3 = '0;
      m_sel3 = '0; m_data3 = '0;
      m_addr3 = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
      wb_ack3 = 1'b0;
      wb_rdata3 = '0;

      // ---- reset state ----
      #1;
      check("rst_gnt", gnt, 2'b00);
      check("rst_wb_cyc", wb_cyc, 1'b0);
      check("rst_m_ack", m_ack, 2'b00);
      check("rst_rdata_pass", m_rdata, 32'hDEAD_BEEF);
      wb_ack = 1'b0;
      tick();
      tick();
      rst  = 1'b0;
      rst3 = 1'b0;

      // ---- T1: m0 classic read at 0x100 ----
      set_m(0, 1'b1, 1'b1, 1'b0, WB_CTI_CLASSIC, 32'h100, 32'h0, 4'hF);
      #1;
      check("t1_gnt_before_edge", gnt, 2'b00);
      tick();
      check("t1_gnt", gnt, 2'b01);
      check("t1_wb_cyc", wb_cyc, 1'b1);
      check("t1_wb_stb", wb_stb, 1'b1);
      check("t1_wb_addr", wb_addr, 32'h100);
      wb_ack   = 1'b1;
      wb_rdata = 32'hCAFE_0100;
      #1;
      check("t1_m_ack", m_ack, 2'b01);
      check("t1_rdata", m_rdata, 32'hCAFE_0100);
      tick();
      wb_ack = 1'b0;
      set_m(0, 1'b0, 1'b0, 1'b0, WB_CTI_CLASSIC, 32'h100, 32'h0, 4'hF);
      #1;
      check("t1_cyc_drop", wb_cyc, 1'b0);
      tick();
      check("t1_idle", gnt, 2'b00);

      // ---- T2: simultaneous request after reset, zero-gap handoff ----
      pulse_rst();
      set_m(0, 1'b1, 1'b1, 1'b0, WB_CTI_CLASSIC, 32'h110, 32'h0, 4'hF);
      set_m(1, 1'b1, 1'b1, 1'b0, WB_CTI_CLASSIC, 32'h210, 32'h0, 4'hF);
      tick();
      check("t2_first_m0", gnt, 2'b01);
      check("t2_addr_m0", wb_addr, 32'h110);
      tick();
      check("t2_hold", gnt, 2'b01);
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      tick();
      check("t2_handoff_m1", gnt, 2'b10);
      check("t2_addr_m1", wb_addr, 32'h210);
      check("t2_cyc_m1", wb_cyc, 1'b1);
      m_cyc[1] = 1'b0;
      m_stb[1] = 1'b0;
      tick();
      check("t2_idle", gnt, 2'b00);

      // ---- T3: m1 8-beat INCR burst, m0 requests mid-burst ----
      set_m(1, 1'b1, 1'b1, 1'b0, WB_CTI_INCR, 32'h200, 32'h0, 4'hF);
      tick();
      check("t3_gnt_m1", gnt, 2'b10);
      for (int b = 0; b < 8; b++) begin
         set_m(1, 1'b1, 1'b1, 1'b0, (b == 7) ? WB_CTI_EOB : WB_CTI_INCR,
               32'h200 + 32'(4 * b), 32'h0, 4'hF);
         if (b == 2) begin
            set_m(0, 1'b1, 1'b1, 1'b0, WB_CTI_CLASSIC, 32'h300, 32'h0, 4'hF);
         end
         wb_ack = 1'b1;
         #1;
         check($sformatf("t3_gnt_beat%0d", b), gnt, 2'b10);
         check($sformatf("t3_ack_beat%0d", b), m_ack, 2'b10);
         check($sformatf("t3_addr_beat%0d", b), wb_addr, 32'h200 + 32'(4 * b));
         if (b == 7) begin
            check("t3_cti_eob", wb_cti, WB_CTI_EOB);
         end
         tick();
      end
      wb_ack = 1'b0;
      m_cyc[1] = 1'b0;
      m_stb[1] = 1'b0;
      #1;
      check("t3_gnt_at_release", gnt, 2'b10);
      tick();
      check("t3_m0_granted", gnt, 2'b01);
      check("t3_m0_addr", wb_addr, 32'h300);
      m_cyc[0] = 1'b0;
      m_stb[0] = 1'b0;
      tick();
      check("t3_idle", gnt, 2'b00);

      // ---- T4: both masters keep re-requesting, single writes alternate ----
      pulse_rst();
      set_m(0, 1'b1, 1'b1, 1'b1, WB_CTI_CLASSIC, 32'h500, 32'hA0A0_0000, 4'h1);
      set_m(1, 1'b1, 1'b1, 1'b1, WB_CTI_CLASSIC, 32'h600, 32'hB1B1_1111, 4'h2);
      tick();
      for (int t = 0; t < 4; t++) begin
         exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
         check($sformatf("t4_gnt_%0d", t), gnt, exp_g);
         check($sformatf("t4_sel_%0d", t), wb_sel, (t % 2 == 0) ? 4'h1 : 4'h2);
         check($sformatf("t4_data_%0d", t), wb_data,
               (t % 2 == 0) ? 32'hA0A0_0000 : 32'hB1B1_1111);
         check($sformatf("t4_we_%0d", t), wb_we, 1'b1);
         wb_ack = 1'b1;
         #1;
         check($sformatf("t4_ack_%0d", t), m_ack, exp_g);
         tick();
         wb_ack = 1'b0;
         m_cyc = m_cyc & ~exp_g;
         m_stb = m_stb & ~exp_g;
         #1;
         check($sformatf("t4_release_%0d", t), wb_cyc, 1'b0);
         tick();
         m_cyc = m_cyc | exp_g;
         m_stb = m_stb | exp_g;
      end
      m_cyc = '0;
      m_stb = '0;
      m_we  = '0;
      tick();
      tick();
      check("t4_idle", gnt, 2'b00);

      // ---- T5: asynchronous reset mid-burst while m1 owns ----
      pulse_rst();
      set_m(1, 1'b1, 1'b1, 1'b0, WB_CTI_INCR, 32'h400, 32'h0, 4'hF);
      tick();
      check("t5_gnt_m1", gnt, 2'b10);
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check("t5_rst_cyc", wb_cyc, 1'b0);
      check("t5_rst_stb", wb_stb, 1'b0);
      check("t5_rst_gnt", gnt, 2'b00);
      set_m(0, 1'b1, 1'b1, 1'b0, WB_CTI_CLASSIC, 32'h440, 32'h0, 4'hF);
      rst = 1'b0;
      tick();
      check("t5_m0_wins", gnt, 2'b01);
      check("t5_m0_addr", wb_addr, 32'h440);
      m_cyc = '0;
      m_stb = '0;
      tick();

      // ---- T6: three masters, release in turn, stray ACK in idle ----
      m_cyc3 = 3'b111;
      m_stb3 = 3'b111;
      tick();
      check("t6_gnt0", gnt3, 3'b001);
      check("t6_addr0", wb_addr3, 32'h1000);
      for (int r = 0; r < 3; r++) begin
         exp3 = 3'b001 << r;
         m_cyc3 = m_cyc3 & ~exp3;
         m_stb3 = m_stb3 & ~exp3;
         tick();
         m_cyc3 = m_cyc3 | exp3;
         m_stb3 = m_stb3 | exp3;
         exp3 = 3'b001 << ((r + 1) % 3);
         check($sformatf("t6_gnt_after_release%0d", r), gnt3, exp3);
         check($sformatf("t6_addr_after_release%0d", r), wb_addr3,
               32'h1000 * 32'(((r + 1) % 3) + 1));
         if (r == 0) begin
            wb_ack3 = 1'b1;
            #1;
            check("t6_ack_m1", m_ack3, 3'b010);
            wb_ack3 = 1'b0;
         end
      end
      m_cyc3 = '0;
      m_stb3 = '0;
      tick();
      check("t6_idle", gnt3, 3'b000);
      wb_ack3 = 1'b1;
      #1;
      check("t6_stray_ack", m_ack3, 3'b000);
      wb_ack3 = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
